// File: rtl/line_mem_responder.sv
// Memory-side responder: fixed-latency aligned 4-word line reads and single-word
// writes, with BR/BG handover of the word memory to a DMA engine.
module line_mem_responder #(
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic [63:0]       line_data,
  output logic              line_valid,
  output logic              write_done,
  output logic              busy,
  input  logic              BR,
  output logic              BG,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [15:0]       dma_wdata
);

  // MEM_WORDS is a power of two, so dropping the upper address bits is the modulo.
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GRANT} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               op_write_q, op_write_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [63:0]        line_data_q;
  logic               line_valid_q, write_done_q;

  logic [15:0]        mem [MEM_WORDS];
  logic               resp_fire;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [15:0]        mem_wdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W], dma_addr[ADDR_W-1:IDX_W]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (BR) begin
          state_d = GRANT;
        end else if (req_read) begin
          addr_d     = {req_addr[IDX_W-1:2], 2'b00};
          op_write_d = 1'b0;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = WAIT;
        end else if (req_write) begin
          addr_d     = req_addr[IDX_W-1:0];
          wdata_d    = req_wdata;
          op_write_d = 1'b1;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      GRANT:   if (!BR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    BG        = (state_q == GRANT);
    resp_fire = (state_q == WAIT) && (cnt_q == 4'd0);
  end

  // Single write port shared by the requester and the DMA; the two never overlap
  // because they live in different states. Reset suppresses any commit.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    if (reset_n) begin
      if (resp_fire && op_write_q) begin
        mem_we = 1'b1;
      end else if (state_q == GRANT && dma_we) begin
        mem_we    = 1'b1;
        mem_waddr = dma_addr[IDX_W-1:0];
        mem_wdata = dma_wdata;
      end
    end
  end

  // NOTE: the memory array has no reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_data_q  <= '0;
      line_valid_q <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      line_valid_q <= resp_fire && !op_write_q;
      write_done_q <= resp_fire && op_write_q;
      if (resp_fire && !op_write_q) begin
        line_data_q <= {mem[addr_q | IDX_W'(3)], mem[addr_q | IDX_W'(2)],
                        mem[addr_q | IDX_W'(1)], mem[addr_q]};
      end
    end
  end

  assign line_data  = line_data_q;
  assign line_valid = line_valid_q;
  assign write_done = write_done_q;

endmodule
